// File: rtl/data_mem_responder_pkg.sv
// rtl/data_mem_responder_pkg.sv - shared encodings and default widths for the data-memory responder
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } dmem_state_e;

    localparam logic [3:0] OP_LOAD  = 4'b0001;
    localparam logic [3:0] OP_STORE = 4'b0010;

    localparam int DMEM_DATA_W  = 32;
    localparam int DMEM_ADDR_W  = 12;
    localparam int DMEM_DEPTH   = 256;
    localparam int DMEM_LATENCY = 2;

endpackage

// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - request/response handshake bundle between load/store unit and data memory
interface data_mem_responder_if
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              busy;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

endinterface

// File: rtl/data_mem_responder_array.sv
// rtl/data_mem_responder_array.sv - single-port synchronous word RAM with one-cycle registered read
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DATA_W = DMEM_DATA_W,
    parameter int DEPTH  = DMEM_DEPTH,
    parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // No reset on contents or read register: the array is plain storage.
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data-memory target with wait states, one outstanding transaction and range errors
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_W  = DMEM_DATA_W,
    parameter int ADDR_W  = DMEM_ADDR_W,
    parameter int DEPTH   = DMEM_DEPTH,
    parameter int LATENCY = DMEM_LATENCY
) (
    input  logic clk,
    input  logic rst,
    data_mem_responder_if.slave bus
);

    localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    dmem_state_e       state_q;
    logic [3:0]        cnt_q;
    logic              wr_q;
    logic              err_q;
    logic [IDX_W-1:0]  addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;

    logic              accept;
    logic              addr_err;
    logic              ram_en;
    logic              ram_we;
    logic              ram_re;
    logic [IDX_W-1:0]  ram_addr;
    logic [DATA_W-1:0] ram_rdata;

    assign accept   = (state_q == IDLE) && bus.req_valid;
    // Compare one bit wider than the address so DEPTH == 2**ADDR_W cannot wrap.
    assign addr_err = {1'b0, bus.req_addr} >= DEPTH_L;

    // The read is launched the cycle before ACCESS so the RAM output is ready in ACCESS.
    assign ram_re   = ((LATENCY == 0) && accept) || ((state_q == WAIT) && (cnt_q == 4'd0));
    assign ram_we   = (state_q == ACCESS) && wr_q && !err_q && !rst;
    assign ram_en   = ram_re || ram_we;
    assign ram_addr = (state_q == IDLE) ? bus.req_addr[IDX_W-1:0] : addr_q;

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk     (clk),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            wr_q        <= 1'b0;
            err_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        wr_q    <= bus.req_write;
                        err_q   <= addr_err;
                        addr_q  <= bus.req_addr[IDX_W-1:0];
                        wdata_q <= bus.req_wdata;
                        if (LATENCY > 0) begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_INIT;
                        end else begin
                            state_q <= ACCESS;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= ACCESS;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ACCESS: begin
                    rsp_rdata_q <= (wr_q || err_q) ? '0 : ram_rdata;
                    rsp_err_q   <= err_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule
